// File: rtl/mips_multicycle_control_if.sv
// Control-unit bundle between the IR/datapath and mips_multicycle_control.
// master = control unit, slave = datapath side.
interface mips_multicycle_control_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               stall;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               zero_imm;
    logic               lui;
    logic               instr_done;
    logic               mem_error;
    logic               illegal_op;
    logic [3:0]         state;

    modport master (
        input  op, zero, mem_ready, stall,
        output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               zero_imm, lui, instr_done, mem_error, illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready, stall,
        input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               zero_imm, lui, instr_done, mem_error, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait-states, stall and timeout.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of NOP-ing them.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4 on mem_ready
// DECODE    | latch opcode, precompute branch target
// MEM_ADDR  | compute Rs+imm for LW/SW
// MEM_READ  | data read, wait for mem_ready
// MEM_WB    | write MDR to Rt
// MEM_WRITE | data write, wait for mem_ready
// EXEC_R    | R-type ALU op
// EXEC_I    | immediate ALU op
// ALU_WB    | write ALUOut to Rd/Rt
// BRANCH    | compare, conditional PC load
// JUMP      | PC <= jump address
// JAL       | PC <= jump address, ra <= PC
// TRAP      | illegal opcode, held until reset
// ERR       | memory timeout, held until reset
module mips_multicycle_control #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    mips_multicycle_control_if.master bus
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                           OP_ANDI  = 6'h0c, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                           OP_LW    = 6'h23, OP_SW  = 6'h2b;

    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(0), ALU_OR  = ALUOP_W'(1),
                                   ALU_ADD = ALUOP_W'(3), ALU_SUB = ALUOP_W'(4),
                                   ALU_LUI = ALUOP_W'(5), ALU_JAL = ALUOP_W'(6),
                                   ALU_FUNCT = ALUOP_W'(7);

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
        MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
        ALU_WB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, JAL = 4'd11,
        TRAP = 4'd12, ERR = 4'd13
    } stateT;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    localparam stateT ILLEGAL_NEXT = TRAP;
`else
    localparam stateT ILLEGAL_NEXT = FETCH;
`endif

    stateT              stateQ, nextState;
    logic [5:0]         opQ;
    logic [CNT_W-1:0]   cntQ;
    logic               doneQ;
    logic               waitState, timeoutHit;
    logic               pcWrite, irWrite, iOrD, memRead, memWrite, regWrite;
    logic               aluSrcA, zeroImm, luiSel;
    logic [1:0]         pcSrc, regDst, memToReg, aluSrcB;
    logic [ALUOP_W-1:0] aluOp;

    assign waitState = ((stateQ == FETCH) || (stateQ == MEM_READ) || (stateQ == MEM_WRITE))
                       && !bus.mem_ready;

    generate
        if (MEM_TIMEOUT > 0) begin : gTimeout
            assign timeoutHit = waitState && (cntQ == CNT_W'(MEM_TIMEOUT - 1));
        end else begin : gNoTimeout
            assign timeoutHit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= FETCH;
            opQ    <= '0;
            cntQ   <= '0;
            doneQ  <= 1'b0;
        end else if (!bus.stall) begin
            stateQ <= nextState;
            // Retire pulse shows in the first cycle of the following FETCH.
            doneQ  <= (stateQ != FETCH) && (nextState == FETCH);
            if (stateQ == DECODE) opQ <= bus.op;
            if ((MEM_TIMEOUT == 0) || (nextState != stateQ) || !waitState) cntQ <= '0;
            else                                                          cntQ <= cntQ + CNT_W'(1);
        end
    end

    always_comb begin
        nextState = stateQ;
        pcWrite   = 1'b0;  pcSrc    = 2'b00; irWrite  = 1'b0; iOrD    = 1'b0;
        memRead   = 1'b0;  memWrite = 1'b0;  regWrite = 1'b0; regDst  = 2'b00;
        memToReg  = 2'b00; aluSrcA  = 1'b0;  aluSrcB  = 2'b00; aluOp  = ALU_AND;
        zeroImm   = 1'b0;  luiSel   = 1'b0;
        case (stateQ)
            FETCH: begin
                memRead = 1'b1; aluSrcB = 2'b01; aluOp = ALU_ADD;
                if (bus.mem_ready) begin
                    irWrite = 1'b1; pcWrite = 1'b1; nextState = DECODE;
                end else if (timeoutHit) begin
                    nextState = ERR;
                end
            end
            DECODE: begin
                aluSrcB = 2'b11; aluOp = ALU_ADD;
                case (bus.op)
                    OP_RTYPE:                         nextState = EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: nextState = EXEC_I;
                    OP_LW, OP_SW:                     nextState = MEM_ADDR;
                    OP_BEQ, OP_BNE:                   nextState = BRANCH;
                    OP_J:                             nextState = JUMP;
                    OP_JAL:                           nextState = JAL;
                    default:                          nextState = ILLEGAL_NEXT;
                endcase
            end
            MEM_ADDR: begin
                aluSrcA = 1'b1; aluSrcB = 2'b10; aluOp = ALU_ADD;
                nextState = (opQ == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                iOrD = 1'b1; memRead = 1'b1;
                if (bus.mem_ready)   nextState = MEM_WB;
                else if (timeoutHit) nextState = ERR;
            end
            MEM_WB: begin
                regWrite = 1'b1; memToReg = 2'b01; nextState = FETCH;
            end
            MEM_WRITE: begin
                iOrD = 1'b1; memWrite = 1'b1;
                if (bus.mem_ready)   nextState = FETCH;
                else if (timeoutHit) nextState = ERR;
            end
            EXEC_R: begin
                aluSrcA = 1'b1; aluOp = ALU_FUNCT; nextState = ALU_WB;
            end
            EXEC_I: begin
                aluSrcA = 1'b1; aluSrcB = 2'b10; nextState = ALU_WB;
                case (opQ)
                    OP_ORI:  begin aluOp = ALU_OR;  zeroImm = 1'b1; end
                    OP_ANDI: begin aluOp = ALU_AND; zeroImm = 1'b1; end
                    OP_LUI:  begin aluOp = ALU_LUI; luiSel  = 1'b1; end
                    default: aluOp = ALU_ADD;
                endcase
            end
            ALU_WB: begin
                regWrite = 1'b1; regDst = (opQ == OP_RTYPE) ? 2'b01 : 2'b00; nextState = FETCH;
            end
            BRANCH: begin
                aluSrcA = 1'b1; aluOp = ALU_SUB; pcSrc = 2'b01;
                pcWrite = ((opQ == OP_BEQ) && bus.zero) || ((opQ == OP_BNE) && !bus.zero);
                nextState = FETCH;
            end
            JUMP: begin
                pcSrc = 2'b10; pcWrite = 1'b1; nextState = FETCH;
            end
            JAL: begin
                pcSrc = 2'b10; pcWrite = 1'b1; regWrite = 1'b1; regDst = 2'b10;
                memToReg = 2'b10; aluOp = ALU_JAL; nextState = FETCH;
            end
            TRAP, ERR: nextState = stateQ;
            default:   nextState = FETCH;
        endcase
    end

    // Write-type strobes die under stall; everything dies under reset.
    assign bus.pc_write   = !reset && !bus.stall && pcWrite;
    assign bus.ir_write   = !reset && !bus.stall && irWrite;
    assign bus.reg_write  = !reset && !bus.stall && regWrite;
    assign bus.mem_write  = !reset && !bus.stall && memWrite;
    assign bus.instr_done = !reset && !bus.stall && doneQ;
    assign bus.mem_read   = !reset && memRead;
    assign bus.i_or_d     = !reset && iOrD;
    assign bus.alu_src_a  = !reset && aluSrcA;
    assign bus.zero_imm   = !reset && zeroImm;
    assign bus.lui        = !reset && luiSel;
    assign bus.pc_src     = reset ? 2'b00 : pcSrc;
    assign bus.reg_dst    = reset ? 2'b00 : regDst;
    assign bus.mem_to_reg = reset ? 2'b00 : memToReg;
    assign bus.alu_src_b  = reset ? 2'b00 : aluSrcB;
    assign bus.alu_op     = reset ? '0 : aluOp;
    assign bus.state      = reset ? 4'd0 : stateQ;
    assign bus.mem_error  = !reset && (stateQ == ERR);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_op = !reset && (stateQ == TRAP);
`else
    assign bus.illegal_op = 1'b0;
`endif
endmodule
